instruction_fetch_unit: RTL and testbench

//  PC generator and prefetch buffer upstream of the AXI instruction memory.

---
 rtl/instruction_fetch_unit_if.sv | 48 ++++
 rtl/instruction_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : instruction_fetch_unit_if                                      |
// | Groups the redirect, instruction-memory and decode handshake signals of    |
// | the instruction fetch unit.                                                |
// |   master : fetch-unit side (drives o_*, receives i_*)                      |
// |   slave  : environment side (memory, branch unit, decode)                  |
// | Ports (fetch-unit view):                                                   |
// |   i_Redirect_Valid/i_Redirect_PC   flush and restart request               |
// |   o_Mem_Enable/o_Mem_Addr          fetch request to memory                 |
// |   i_Mem_Instruction/i_Mem_Valid    memory response                         |
// |   i_Mem_Busy                       memory status                           |
// |   o_Decode_Valid/_Instruction/_PC  FIFO head towards decode                |
// |   i_Decode_Ready                   decode accepts head                     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface instruction_fetch_unit_if #(
  parameter int XLEN = 32
) ();
  logic            i_Redirect_Valid;
  logic [XLEN-1:0] i_Redirect_PC;
  logic            o_Mem_Enable;
  logic [XLEN-1:0] o_Mem_Addr;
  logic [XLEN-1:0] i_Mem_Instruction;
  logic            i_Mem_Valid;
  logic            i_Mem_Busy;
  logic            o_Decode_Valid;
  logic [XLEN-1:0] o_Decode_Instruction;
  logic [XLEN-1:0] o_Decode_PC;
  logic            i_Decode_Ready;

  modport master (
    input  i_Redirect_Valid, i_Redirect_PC,
    output o_Mem_Enable, o_Mem_Addr,
    input  i_Mem_Instruction, i_Mem_Valid, i_Mem_Busy,
    output o_Decode_Valid, o_Decode_Instruction, o_Decode_PC,
    input  i_Decode_Ready
  );

  modport slave (
    output i_Redirect_Valid, i_Redirect_PC,
    input  o_Mem_Enable, o_Mem_Addr,
    output i_Mem_Instruction, i_Mem_Valid, i_Mem_Busy,
    input  o_Decode_Valid, o_Decode_Instruction, o_Decode_PC,
    output i_Decode_Ready
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : instruction_fetch_unit                                            |
// | PC generator and prefetch FIFO in front of the instruction memory.         |
// | Issues one fetch at a time, pushes {PC, instruction} into the FIFO and     |
// | presents the FIFO head to decode. Redirects flush the FIFO; a request      |
// | already in flight is drained and its data dropped.                         |
// | Ports:                                                                     |
// |   i_Clock   : clock, rising edge                                           |
// |   i_Reset_N : asynchronous active-low reset                                |
// |   bus       : instruction_fetch_unit_if.master (redirect/memory/decode)    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module instruction_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  wire logic                  i_Clock,
  input  wire logic                  i_Reset_N,
  instruction_fetch_unit_if.master   bus
);

  localparam int            c_AW    = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0] c_DEPTH = (c_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pending;
  logic [c_AW:0]   r_wp;
  logic [c_AW:0]   r_rp;
  logic [XLEN-1:0] r_fifo_pc    [FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_instr [FIFO_DEPTH];

  logic [c_AW:0]   w_count;
  logic [c_AW:0]   w_count_after;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_push;
  logic            w_pop;
  logic            w_unused;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count       = r_wp - r_rp;
  assign w_redirect_pc = {bus.i_Redirect_PC[XLEN-1:2], 2'b00};
  assign w_push        = (r_state == ST_FETCH) && bus.i_Mem_Valid && !bus.i_Redirect_Valid;
  assign w_pop         = (w_count != '0) && bus.i_Decode_Ready && !bus.i_Redirect_Valid;
  assign w_count_after = w_count + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};
  assign w_unused      = &{1'b0, bus.i_Mem_Busy, bus.i_Redirect_PC[1:0]};

  assign bus.o_Mem_Enable         = (r_state != ST_IDLE);
  assign bus.o_Mem_Addr           = r_pc;
  assign bus.o_Decode_Valid       = (w_count != '0);
  assign bus.o_Decode_PC          = r_fifo_pc[r_rp[c_AW-1:0]];
  assign bus.o_Decode_Instruction = r_fifo_instr[r_rp[c_AW-1:0]];

  // Fetch control. r_pc is only changed when no request is outstanding
  // (IDLE) or on the cycle its response arrives, so the memory address is
  // stable for the whole request.
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      r_state   <= ST_IDLE;
      r_pc      <= RESET_PC;
      r_pending <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_Redirect_Valid) begin
            r_pc <= w_redirect_pc;
          end else if (w_count < c_DEPTH) begin
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.i_Mem_Valid) begin
            if (bus.i_Redirect_Valid) begin
              r_pc    <= w_redirect_pc;
              r_state <= ST_IDLE;
            end else begin
              r_pc    <= r_pc + XLEN'(4);
              r_state <= (w_count_after < c_DEPTH) ? ST_FETCH : ST_IDLE;
            end
          end else if (bus.i_Redirect_Valid) begin
            r_pending <= w_redirect_pc;
            r_state   <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Wait out the stale request; the newest redirect target wins.
          if (bus.i_Mem_Valid) begin
            r_pc    <= bus.i_Redirect_Valid ? w_redirect_pc : r_pending;
            r_state <= ST_IDLE;
          end else if (bus.i_Redirect_Valid) begin
            r_pending <= w_redirect_pc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Prefetch FIFO. A redirect empties it and overrides any push/pop.
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
    end else if (bus.i_Redirect_Valid) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wp[c_AW-1:0]]    <= r_pc;
        r_fifo_instr[r_wp[c_AW-1:0]] <= bus.i_Mem_Instruction;
        r_wp                         <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_instruction_fetch_unit                                         |
// | Self-checking bench for instruction_fetch_unit with a memory stub whose    |
// | data is addr ^ 32'hA5A5_0000 and whose latency is selectable.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch_unit;

  localparam logic [31:0] c_KEY = 32'hA5A5_0000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;
  int   lat;
  int   cyc;
  int   hold_err;

  instruction_fetch_unit_if #(.XLEN(32)) bus ();

  instruction_fetch_unit #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .i_Clock   (clk),
    .i_Reset_N (rst_n),
    .bus       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Memory stub: accepts one request when idle, answers after lat cycles with
  // a one-cycle valid pulse, and ignores enable on the cycle valid drops.
  logic        sbusy;
  int          scnt;
  logic [31:0] saddr;
  logic [31:0] fetch_q [$];
  logic [31:0] dq_pc   [$];
  logic [31:0] dq_ins  [$];
  int          dq_cyc  [$];

  assign bus.i_Mem_Busy = sbusy | bus.i_Mem_Valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.i_Mem_Valid       <= 1'b0;
      bus.i_Mem_Instruction <= '0;
      sbusy                 <= 1'b0;
      scnt                  <= 0;
      saddr                 <= '0;
    end else if (bus.i_Mem_Valid) begin
      bus.i_Mem_Valid <= 1'b0;
    end else if (sbusy) begin
      if (scnt <= 1) begin
        bus.i_Mem_Valid       <= 1'b1;
        bus.i_Mem_Instruction <= saddr ^ c_KEY;
        sbusy                 <= 1'b0;
      end else begin
        scnt <= scnt - 1;
      end
    end else if (bus.o_Mem_Enable) begin
      saddr <= bus.o_Mem_Addr;
      fetch_q.push_back(bus.o_Mem_Addr);
      if (lat <= 1) begin
        bus.i_Mem_Valid       <= 1'b1;
        bus.i_Mem_Instruction <= bus.o_Mem_Addr ^ c_KEY;
      end else begin
        sbusy <= 1'b1;
        scnt  <= lat - 1;
      end
    end
  end

  initial hold_err = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (bus.o_Decode_Valid && bus.i_Decode_Ready && !bus.i_Redirect_Valid) begin
        dq_pc.push_back(bus.o_Decode_PC);
        dq_ins.push_back(bus.o_Decode_Instruction);
        dq_cyc.push_back(cyc);
      end
      if (sbusy && (bus.o_Mem_Addr != saddr || !bus.o_Mem_Enable))
        hold_err <= hold_err + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_deliv(input int n, output bit ok);
    int t = 0;
    while (dq_pc.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    ok = (dq_pc.size() >= n);
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout_delivery: got %0d deliveries expected %0d", dq_pc.size(), n);
    end
  endtask

  task automatic wait_fetch(input int n, output bit ok);
    int t = 0;
    while (fetch_q.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    ok = (fetch_q.size() >= n);
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout_fetch: got %0d fetches expected %0d", fetch_q.size(), n);
    end
  endtask

  task automatic wait_busy(output bit ok);
    int t = 0;
    while (!sbusy && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = sbusy;
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout_busy: got 0 expected 1");
    end
  endtask

  task automatic do_reset(input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    rst_n                = 1'b0;
    bus.i_Redirect_Valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    if (redir) begin
      bus.i_Redirect_Valid = 1'b1;
      bus.i_Redirect_PC    = rpc;
      @(negedge clk);
      bus.i_Redirect_Valid = 1'b0;
    end
  endtask

  typedef struct {
    logic [31:0] redir;
    logic [31:0] pc0;
    logic [31:0] ins0;
    logic [31:0] pc1;
  } vec_t;

  vec_t vecs [5];

  initial begin
    bit ok;
    int fb;
    int db;
    int h0;
    int n80;

    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'hA5A5_0100, 32'h0000_0104};
    vecs[1] = '{32'h0000_0203, 32'h0000_0200, 32'hA5A5_0200, 32'h0000_0204};
    vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h1234_5679, 32'h1234_5678, 32'hB791_5678, 32'h1234_567C};
    vecs[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 32'h0000_0000};

    n_checks = 0;
    n_err    = 0;
    cyc      = 0;
    lat      = 1;
    rst_n    = 1'b0;
    bus.i_Redirect_Valid = 1'b0;
    bus.i_Redirect_PC    = '0;
    bus.i_Decode_Ready   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_enable", {31'b0, bus.o_Mem_Enable}, 32'd0);
    check("rst_addr", bus.o_Mem_Addr, 32'h0);
    check("rst_dvalid", {31'b0, bus.o_Decode_Valid}, 32'd0);
    check("rst_dpc", bus.o_Decode_PC, 32'h0);
    check("rst_dins", bus.o_Decode_Instruction, 32'h0);

    // 1: streaming from ROM, one delivery every 2 cycles
    bus.i_Decode_Ready = 1'b1;
    db = dq_pc.size();
    do_reset(1'b0, 32'h0);
    wait_deliv(db + 3, ok);
    if (ok) begin
      check("t1_pc0", dq_pc[db], 32'h0);
      check("t1_pc1", dq_pc[db+1], 32'h4);
      check("t1_pc2", dq_pc[db+2], 32'h8);
      check("t1_ins1", dq_ins[db+1], 32'hA5A5_0004);
      check("t1_gap01", 32'(dq_cyc[db+1] - dq_cyc[db]), 32'd2);
      check("t1_gap12", 32'(dq_cyc[db+2] - dq_cyc[db+1]), 32'd2);
    end

    // 2: decode stalled, FIFO fills and fetch stops; one pop restarts it
    bus.i_Decode_Ready = 1'b0;
    do_reset(1'b0, 32'h0);
    fb = fetch_q.size();
    repeat (20) @(negedge clk);
    check("t2_full_enable", {31'b0, bus.o_Mem_Enable}, 32'd0);
    check("t2_full_valid", {31'b0, bus.o_Decode_Valid}, 32'd1);
    check("t2_head_pc", bus.o_Decode_PC, 32'h0);
    check("t2_nfetch", 32'(fetch_q.size() - fb), 32'd4);
    bus.i_Decode_Ready = 1'b1;
    @(negedge clk);
    bus.i_Decode_Ready = 1'b0;
    check("t2_head_pc_after_pop", bus.o_Decode_PC, 32'h4);
    check("t2_head_ins_after_pop", bus.o_Decode_Instruction, 32'hA5A5_0004);
    wait_fetch(fb + 5, ok);
    if (ok) check("t2_refetch_addr", fetch_q[fb+4], 32'h10);
    repeat (10) @(negedge clk);
    check("t2_refull_enable", {31'b0, bus.o_Mem_Enable}, 32'd0);
    check("t2_refull_nfetch", 32'(fetch_q.size() - fb), 32'd5);

    // 3: slow memory, redirect during request: address held, data dropped
    lat = 5;
    bus.i_Decode_Ready = 1'b1;
    do_reset(1'b1, 32'h2000);
    fb = fetch_q.size();
    db = dq_pc.size();
    h0 = hold_err;
    wait_busy(ok);
    @(negedge clk);
    bus.i_Redirect_Valid = 1'b1;
    bus.i_Redirect_PC    = 32'h40;
    @(negedge clk);
    bus.i_Redirect_Valid = 1'b0;
    check("t3_addr_in_flush", bus.o_Mem_Addr, 32'h2000);
    check("t3_enable_in_flush", {31'b0, bus.o_Mem_Enable}, 32'd1);
    wait_fetch(fb + 2, ok);
    if (ok) begin
      check("t3_first_fetch", fetch_q[fb], 32'h2000);
      check("t3_next_fetch", fetch_q[fb+1], 32'h40);
      check("t3_dropped", 32'(dq_pc.size() - db), 32'd0);
      check("t3_addr_hold", 32'(hold_err - h0), 32'd0);
    end
    wait_deliv(db + 1, ok);
    if (ok) check("t3_first_pc", dq_pc[db], 32'h40);

    // 4: redirect with 3 entries queued, pop and response in the same cycle
    lat = 1;
    bus.i_Decode_Ready = 1'b0;
    do_reset(1'b0, 32'h0);
    fb = fetch_q.size();
    wait_fetch(fb + 4, ok);
    db = dq_pc.size();
    bus.i_Redirect_Valid = 1'b1;
    bus.i_Redirect_PC    = 32'h100;
    bus.i_Decode_Ready   = 1'b1;
    @(negedge clk);
    bus.i_Redirect_Valid = 1'b0;
    check("t4_valid_after_redirect", {31'b0, bus.o_Decode_Valid}, 32'd0);
    wait_deliv(db + 1, ok);
    if (ok) check("t4_first_pc", dq_pc[db], 32'h100);
    check("t4_next_fetch", fetch_q[fb+4], 32'h100);

    // 5: two redirects, second while flushing: latest wins
    lat = 5;
    do_reset(1'b0, 32'h0);
    fb = fetch_q.size();
    db = dq_pc.size();
    wait_busy(ok);
    @(negedge clk);
    bus.i_Redirect_Valid = 1'b1;
    bus.i_Redirect_PC    = 32'h80;
    @(negedge clk);
    bus.i_Redirect_PC    = 32'h90;
    @(negedge clk);
    bus.i_Redirect_Valid = 1'b0;
    wait_deliv(db + 1, ok);
    if (ok) check("t5_first_pc", dq_pc[db], 32'h90);
    n80 = 0;
    for (int i = fb; i < fetch_q.size(); i++)
      if (fetch_q[i] == 32'h80) n80++;
    check("t5_no_fetch_80", 32'(n80), 32'd0);
    check("t5_second_fetch", fetch_q[fb+1], 32'h90);

    // 6: reset mid-request clears outputs asynchronously
    do_reset(1'b1, 32'h300);
    wait_busy(ok);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_enable", {31'b0, bus.o_Mem_Enable}, 32'd0);
    check("t6_addr", bus.o_Mem_Addr, 32'h0);
    check("t6_dvalid", {31'b0, bus.o_Decode_Valid}, 32'd0);
    fb = fetch_q.size();
    db = dq_pc.size();
    @(negedge clk);
    rst_n = 1'b1;
    wait_deliv(db + 1, ok);
    if (ok) check("t6_first_pc", dq_pc[db], 32'h0);
    check("t6_first_fetch", fetch_q[fb], 32'h0);

    // Table: redirect targets, alignment masking and PC wrap
    lat = 1;
    for (int v = 0; v < 5; v++) begin
      do_reset(1'b1, vecs[v].redir);
      db = dq_pc.size();
      wait_deliv(db + 2, ok);
      if (ok) begin
        check($sformatf("vec%0d_pc0", v), dq_pc[db], vecs[v].pc0);
        check($sformatf("vec%0d_ins0", v), dq_ins[db], vecs[v].ins0);
        check($sformatf("vec%0d_pc1", v), dq_pc[db+1], vecs[v].pc1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
